// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
//   Shared constants for the execute stage and its ALU:
//   - ALUOP_* : 3-bit ALU operation encodings
//   - BR_*    : branch-type encodings carried with each decoded op
//   - ex_state_t : execute-stage run/halt state
//   - is_branch() : true for the two conditional branch encodings
// ---------------------------------------------------------------------------
package ex_pkg;

   localparam logic [2:0] ALUOP_AND  = 3'b000;
   localparam logic [2:0] ALUOP_OR   = 3'b001;
   localparam logic [2:0] ALUOP_ADD  = 3'b010;
   localparam logic [2:0] ALUOP_LUI  = 3'b011;
   localparam logic [2:0] ALUOP_SLTU = 3'b100;
   localparam logic [2:0] ALUOP_SUB  = 3'b110;
   localparam logic [2:0] ALUOP_SLT  = 3'b111;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } ex_state_t;

   // Encoding 11 is reserved and behaves like "no branch".
   function automatic logic is_branch(input logic [1:0] br_type);
      return (br_type == BR_BEQ) || (br_type == BR_BNE);
   endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational ALU.
//   Ports:
//     a, b       : operands (DATA_WIDTH)
//     alu_op     : operation select (ex_pkg ALUOP_*)
//     result     : operation result
//     overflow   : signed overflow, only for ADD/SUB
//     carry_out  : carry out of the shared adder (no-borrow on SUB)
//     zero       : result == 0
// ---------------------------------------------------------------------------
module alu
   import ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [2:0]            alu_op,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow,
   output logic                  carry_out,
   output logic                  zero
);

   localparam int LUI_SHIFT = 16;

   logic [DATA_WIDTH-1:0] and_bits;
   logic [DATA_WIDTH-1:0] or_bits;
   logic [DATA_WIDTH-1:0] b_eff;
   logic [DATA_WIDTH-1:0] sum;
   logic                  carry;
   logic                  is_sub;
   logic                  is_addsub;

   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_logic
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
   end

   // One adder serves ADD and SUB: SUB is a + ~b + 1.
   assign is_sub    = (alu_op == ALUOP_SUB);
   assign is_addsub = is_sub || (alu_op == ALUOP_ADD);
   assign b_eff     = is_sub ? ~b : b;
   assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};

   always_comb begin
      result = '0;
      case (alu_op)
         ALUOP_AND:  result = and_bits;
         ALUOP_OR:   result = or_bits;
         ALUOP_ADD:  result = sum;
         ALUOP_SUB:  result = sum;
         ALUOP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALUOP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
         ALUOP_LUI:  result = b << LUI_SHIFT;
         default:    result = '0;
      endcase
   end

   // Signed overflow: operands (after the SUB inversion) agree in sign but
   // the sum does not.
   assign overflow  = is_addsub
                    & (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1])
                    & (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
   assign carry_out = carry;
   assign zero      = (result == '0);

endmodule

// File: rtl/alu_ex_stage.sv
// ---------------------------------------------------------------------------
// alu_ex_stage
//   Execute stage around the combinational ALU. Takes decoded ops from ID on
//   a valid/ready handshake, resolves BEQ/BNE and signed-overflow traps, and
//   registers the result for MEM/WB (latency 1, one-deep, full throughput).
//   An accepted op that raises an overflow exception halts intake until
//   flush.
//   Ports:
//     clk, resetn           : clock, asynchronous active-low reset
//     flush                 : drop in-flight op and pending input, resume
//     in_valid / in_ready   : input handshake from ID
//     in_alu_op, in_trap_ov, in_br_type, in_src_a, in_src_b,
//     in_wdest, in_wen, in_pc, in_br_target : decoded op fields
//     out_valid / out_ready : output handshake to MEM/WB
//     out_result, out_wdest, out_wen, out_pc,
//     out_br_taken, out_br_target, out_exc_ov : registered op results
// ---------------------------------------------------------------------------
module alu_ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5,
   parameter int PC_W       = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_alu_op,
   input  logic                  in_trap_ov,
   input  logic [1:0]            in_br_type,
   input  logic [DATA_WIDTH-1:0] in_src_a,
   input  logic [DATA_WIDTH-1:0] in_src_b,
   input  logic [REG_AW-1:0]     in_wdest,
   input  logic                  in_wen,
   input  logic [PC_W-1:0]       in_pc,
   input  logic [PC_W-1:0]       in_br_target,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [REG_AW-1:0]     out_wdest,
   output logic                  out_wen,
   output logic [PC_W-1:0]       out_pc,
   output logic                  out_br_taken,
   output logic [PC_W-1:0]       out_br_target,
   output logic                  out_exc_ov
);

   ex_state_t             state_reg, state_next;
   logic                  out_valid_reg, out_valid_next;
   logic [DATA_WIDTH-1:0] result_reg;
   logic [REG_AW-1:0]     wdest_reg;
   logic                  wen_reg;
   logic [PC_W-1:0]       pc_reg;
   logic                  br_taken_reg;
   logic [PC_W-1:0]       br_target_reg;
   logic                  exc_ov_reg;

   logic [2:0]            alu_op_sel;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_overflow;
   logic                  alu_zero;
   logic                  alu_carry_unused;

   logic                  op_is_branch;
   logic                  br_taken_calc;
   logic                  exc_calc;
   logic                  wen_calc;
   logic                  accept;

   // Branches compare via SUB so that Zero means a == b.
   assign op_is_branch = is_branch(in_br_type);
   assign alu_op_sel   = op_is_branch ? ALUOP_SUB : in_alu_op;

   alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .a         (in_src_a),
      .b         (in_src_b),
      .alu_op    (alu_op_sel),
      .result    (alu_result),
      .overflow  (alu_overflow),
      .carry_out (alu_carry_unused),
      .zero      (alu_zero)
   );

   always_comb begin
      br_taken_calc = 1'b0;
      case (in_br_type)
         BR_BEQ:  br_taken_calc = alu_zero;
         BR_BNE:  br_taken_calc = ~alu_zero;
         default: br_taken_calc = 1'b0;
      endcase
   end

   assign exc_calc = in_trap_ov & alu_overflow;
   // r0 is hard-wired, so a write to it is suppressed here too.
   assign wen_calc = in_wen & ~op_is_branch & ~exc_calc & (in_wdest != '0);

   // Ready whenever the output slot is empty or emptying this edge.
   assign in_ready = (state_reg == ST_RUN) & ~flush & (~out_valid_reg | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:  if (accept && exc_calc) state_next = ST_HALT;
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_RUN;
      endcase
      if (flush) state_next = ST_RUN;
   end

   always_comb begin
      out_valid_next = out_valid_reg;
      if (flush)          out_valid_next = 1'b0;
      else if (accept)    out_valid_next = 1'b1;
      else if (out_ready) out_valid_next = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_RUN;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // Payload loads only on accept, so it holds while back-pressured.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         result_reg    <= '0;
         wdest_reg     <= '0;
         wen_reg       <= 1'b0;
         pc_reg        <= '0;
         br_taken_reg  <= 1'b0;
         br_target_reg <= '0;
         exc_ov_reg    <= 1'b0;
      end else if (accept) begin
         result_reg    <= alu_result;
         wdest_reg     <= in_wdest;
         wen_reg       <= wen_calc;
         pc_reg        <= in_pc;
         br_taken_reg  <= br_taken_calc;
         br_target_reg <= in_br_target;
         exc_ov_reg    <= exc_calc;
      end
   end

   assign out_valid     = out_valid_reg;
   assign out_result    = result_reg;
   assign out_wdest     = wdest_reg;
   assign out_wen       = wen_reg;
   assign out_pc        = pc_reg;
   assign out_br_taken  = br_taken_reg;
   assign out_br_target = br_target_reg;
   assign out_exc_ov    = exc_ov_reg;

endmodule

// File: tb/tb_alu_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_ex_stage
//   Scoreboard bench for alu_ex_stage (DATA_WIDTH=32). The driver pushes the
//   expected response of every accepted op into a queue; an independent
//   monitor pops and compares whenever MEM/WB consumes an output.
// ---------------------------------------------------------------------------
module tb_alu_ex_stage;

   typedef struct packed {
      logic [2:0]  op;
      logic        trap;
      logic [1:0]  br;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wdest;
      logic        wen;
      logic [31:0] pc;
      logic [31:0] tgt;
   } op_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  wdest;
      logic        wen;
      logic [31:0] pc;
      logic        br_taken;
      logic [31:0] br_target;
      logic        exc_ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_alu_op;
   logic        in_trap_ov;
   logic [1:0]  in_br_type;
   logic [31:0] in_src_a;
   logic [31:0] in_src_b;
   logic [4:0]  in_wdest;
   logic        in_wen;
   logic [31:0] in_pc;
   logic [31:0] in_br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_wdest;
   logic        out_wen;
   logic [31:0] out_pc;
   logic        out_br_taken;
   logic [31:0] out_br_target;
   logic        out_exc_ov;

   int   vectors     = 0;
   int   miscompares = 0;
   int   pops        = 0;
   bit   halted      = 1'b0;
   exp_t sb[$];

   logic [2:0] legal_ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100};

   always #5 clk = ~clk;

   alu_ex_stage #(
      .DATA_WIDTH (32),
      .REG_AW     (5),
      .PC_W       (32)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_alu_op     (in_alu_op),
      .in_trap_ov    (in_trap_ov),
      .in_br_type    (in_br_type),
      .in_src_a      (in_src_a),
      .in_src_b      (in_src_b),
      .in_wdest      (in_wdest),
      .in_wen        (in_wen),
      .in_pc         (in_pc),
      .in_br_target  (in_br_target),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_wdest     (out_wdest),
      .out_wen       (out_wen),
      .out_pc        (out_pc),
      .out_br_taken  (out_br_taken),
      .out_br_target (out_br_target),
      .out_exc_ov    (out_exc_ov)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Reference model: plain signed/unsigned arithmetic on 64-bit integers.
   function automatic exp_t model(input op_t o);
      exp_t   e;
      logic   is_br;
      logic   [2:0] eff;
      longint sa, sbv, full;
      logic   ov;
      is_br    = (o.br == 2'b01) || (o.br == 2'b10);
      eff      = is_br ? 3'b110 : o.op;
      sa       = longint'($signed(o.a));
      sbv      = longint'($signed(o.b));
      full     = 0;
      ov       = 1'b0;
      e        = '0;
      case (eff)
         3'b000: e.result = o.a & o.b;
         3'b001: e.result = o.a | o.b;
         3'b010: begin
            full     = sa + sbv;
            e.result = full[31:0];
            ov       = (full != longint'($signed(e.result)));
         end
         3'b110: begin
            full     = sa - sbv;
            e.result = full[31:0];
            ov       = (full != longint'($signed(e.result)));
         end
         3'b111: e.result = (sa < sbv) ? 32'd1 : 32'd0;
         3'b100: e.result = (o.a < o.b) ? 32'd1 : 32'd0;
         3'b011: e.result = {o.b[15:0], 16'h0000};
         default: e.result = 32'd0;
      endcase
      e.br_taken  = (o.br == 2'b01) ? (o.a == o.b) :
                    (o.br == 2'b10) ? (o.a != o.b) : 1'b0;
      e.exc_ov    = o.trap && ov;
      e.wen       = o.wen && !is_br && !e.exc_ov && (o.wdest != 5'd0);
      e.wdest     = o.wdest;
      e.pc        = o.pc;
      e.br_target = o.tgt;
      return e;
   endfunction

   function automatic op_t mk(input logic [2:0] op, input logic trap, input logic [1:0] br,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] wdest,
                              input logic wen, input logic [31:0] pc, input logic [31:0] tgt);
      op_t o;
      o.op = op; o.trap = trap; o.br = br; o.a = a; o.b = b;
      o.wdest = wdest; o.wen = wen; o.pc = pc; o.tgt = tgt;
      return o;
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.op    = legal_ops[$urandom_range(0, 6)];
      o.br    = 2'($urandom_range(0, 3));
      o.a     = rand_word();
      o.b     = ($urandom_range(0, 3) == 0) ? o.a : rand_word();
      o.trap  = ((o.op == 3'b010) || (o.op == 3'b110)) && (o.br != 2'b01) && (o.br != 2'b10)
                && ($urandom_range(0, 1) == 1);
      o.wdest = 5'($urandom_range(0, 31));
      o.wen   = 1'($urandom_range(0, 1));
      o.pc    = $urandom();
      o.tgt   = $urandom();
      return o;
   endfunction

   // Called at posedge+1; drives one cycle and returns whether ID's op was taken.
   task automatic drive_cycle(input op_t o, input logic v, input logic ordy, input logic fl,
                              output logic acc);
      exp_t e;
      in_alu_op    = o.op;
      in_trap_ov   = o.trap;
      in_br_type   = o.br;
      in_src_a     = o.a;
      in_src_b     = o.b;
      in_wdest     = o.wdest;
      in_wen       = o.wen;
      in_pc        = o.pc;
      in_br_target = o.tgt;
      in_valid     = v;
      out_ready    = ordy;
      flush        = fl;
      @(negedge clk);
      if (resetn)
         check("in_ready", 64'(in_ready), 64'(!halted && !fl && (!out_valid || ordy)));
      acc = v && in_ready;
      e   = model(o);
      @(posedge clk);
      if (fl) halted = 1'b0;
      if (acc) begin
         sb.push_back(e);
         if (e.exc_ov) halted = 1'b1;
      end
      #1;
   endtask

   // Monitor: pops on consumption, drops on flush, and checks hold stability.
   bit   prev_hold = 1'b0;
   exp_t prev_snap;
   always @(negedge clk) begin
      exp_t snap;
      exp_t e;
      snap = {out_result, out_wdest, out_wen, out_pc, out_br_taken, out_br_target, out_exc_ov};
      if (!resetn) begin
         prev_hold = 1'b0;
      end else begin
         check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
         if (prev_hold)
            check("hold_stable", 64'(snap[63:0] ^ prev_snap[63:0]) | 64'(snap[103:64] ^ prev_snap[103:64]), 64'd0);
         if (out_valid && sb.size() != 0) begin
            if (out_ready) begin
               e = sb.pop_front();
               pops++;
               check("result",    64'(out_result),    64'(e.result));
               check("wdest",     64'(out_wdest),     64'(e.wdest));
               check("wen",       64'(out_wen),       64'(e.wen));
               check("pc",        64'(out_pc),        64'(e.pc));
               check("br_taken",  64'(out_br_taken),  64'(e.br_taken));
               check("br_target", 64'(out_br_target), 64'(e.br_target));
               check("exc_ov",    64'(out_exc_ov),    64'(e.exc_ov));
            end else if (flush) begin
               void'(sb.pop_front());
            end
         end
         prev_hold = out_valid && !out_ready && !flush;
         prev_snap = snap;
      end
   end

   initial begin
      op_t  o;
      op_t  idle;
      logic acc;
      int   acc_cnt;
      int   pops0;
      bit   fl;

      idle         = '0;
      resetn       = 1'b0;
      flush        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      in_alu_op    = '0;
      in_trap_ov   = 1'b0;
      in_br_type   = '0;
      in_src_a     = '0;
      in_src_b     = '0;
      in_wdest     = '0;
      in_wen       = 1'b0;
      in_pc        = '0;
      in_br_target = '0;

      #1;
      check("rst_valid",     64'(out_valid),     64'd0);
      check("rst_result",    64'(out_result),    64'd0);
      check("rst_wdest",     64'(out_wdest),     64'd0);
      check("rst_wen",       64'(out_wen),       64'd0);
      check("rst_pc",        64'(out_pc),        64'd0);
      check("rst_br_taken",  64'(out_br_taken),  64'd0);
      check("rst_br_target", 64'(out_br_target), 64'd0);
      check("rst_exc_ov",    64'(out_exc_ov),    64'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // ADD 7+5 -> 12 to r3
      drive_cycle(mk(3'b010, 1'b0, 2'b00, 32'd7, 32'd5, 5'd3, 1'b1, 32'h100, 32'h0), 1'b1, 1'b1, 1'b0, acc);
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);

      // Trapping SUB overflows, stage halts until flush
      drive_cycle(mk(3'b110, 1'b1, 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'h104, 32'h0),
                  1'b1, 1'b1, 1'b0, acc);
      o = mk(3'b010, 1'b0, 2'b00, 32'd1, 32'd2, 5'd5, 1'b1, 32'h108, 32'h0);
      repeat (3) drive_cycle(o, 1'b1, 1'b1, 1'b0, acc);
      drive_cycle(o, 1'b1, 1'b1, 1'b1, acc);
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);

      // BEQ / BNE with equal operands; in_alu_op must be ignored
      drive_cycle(mk(3'b000, 1'b0, 2'b01, 32'h10, 32'h10, 5'd6, 1'b1, 32'h200, 32'h400), 1'b1, 1'b1, 1'b0, acc);
      drive_cycle(mk(3'b000, 1'b0, 2'b10, 32'h10, 32'h10, 5'd6, 1'b1, 32'h204, 32'h500), 1'b1, 1'b1, 1'b0, acc);
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);

      // Back-pressure: one op held for 3 cycles, next op waits, then both drain
      drive_cycle(mk(3'b001, 1'b0, 2'b00, 32'hF0, 32'h0F, 5'd7, 1'b1, 32'h300, 32'h0), 1'b1, 1'b0, 1'b0, acc);
      o = mk(3'b111, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1, 32'h304, 32'h0);
      repeat (3) drive_cycle(o, 1'b1, 1'b0, 1'b0, acc);
      drive_cycle(o, 1'b1, 1'b1, 1'b0, acc);
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);

      // Streaming: 8 back-to-back ops, 8 consecutive outputs
      acc_cnt = 0;
      pops0   = pops;
      for (int i = 0; i < 8; i++) begin
         o = rand_op();
         o.trap = 1'b0;
         drive_cycle(o, 1'b1, 1'b1, 1'b0, acc);
         if (acc) acc_cnt++;
      end
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);
      check("stream_accepts", 64'(acc_cnt), 64'd8);
      check("stream_outputs", 64'(pops - pops0), 64'd8);

      // Asynchronous reset while an op is held on the output
      drive_cycle(mk(3'b010, 1'b0, 2'b00, 32'd7, 32'd5, 5'd3, 1'b1, 32'h600, 32'h0), 1'b1, 1'b0, 1'b0, acc);
      resetn = 1'b0;
      #1;
      check("async_rst_valid",  64'(out_valid),  64'd0);
      check("async_rst_result", 64'(out_result), 64'd0);
      check("async_rst_wen",    64'(out_wen),    64'd0);
      check("async_rst_pc",     64'(out_pc),     64'd0);
      sb.delete();
      halted = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);

      // Flush beats in_valid: held op and pending op both dropped
      drive_cycle(mk(3'b001, 1'b0, 2'b00, 32'h1, 32'h2, 5'd9, 1'b1, 32'h700, 32'h0), 1'b1, 1'b0, 1'b0, acc);
      drive_cycle(mk(3'b001, 1'b0, 2'b00, 32'h4, 32'h8, 5'd10, 1'b1, 32'h704, 32'h0), 1'b1, 1'b0, 1'b1, acc);
      drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         fl = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
         drive_cycle(rand_op(), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7), fl, acc);
      end

      // Drain
      drive_cycle(idle, 1'b0, 1'b1, 1'b1, acc);
      repeat (3) drive_cycle(idle, 1'b0, 1'b1, 1'b0, acc);
      check("drain_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
